// File: rtl/fe_mul_arbiter.sv
// rtl/fe_mul_arbiter.sv - round-robin arbiter sharing one fe_mulx among NREQ requesters
module fe_mul_arbiter #(
  parameter int NREQ    = 3,
  parameter int WIDTH   = 320,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_op_a,
  input  logic [NREQ*WIDTH-1:0]   req_op_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic [WIDTH-1:0]        req_res,
  output logic [WIDTH-1:0]        mul_op_a,
  output logic [WIDTH-1:0]        mul_op_b,
  output logic                    mul_valid,
  input  logic [WIDTH-1:0]        mul_res,
  input  logic                    mul_done,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant, last_grant_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [15:0]     count, count_nxt;
  logic [NREQ-1:0] req_ready_nxt, req_done_nxt;
  logic [WIDTH-1:0] req_res_nxt, mul_op_a_nxt, mul_op_b_nxt;
  logic            mul_valid_nxt, timeout_err_nxt;

  logic            found;
  logic [GW-1:0]   winner;
  logic [WIDTH-1:0] win_a, win_b;
  logic            expired;

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (idx == GW'(j)) onehot[j] = 1'b1;
    end
  endfunction

  // Search starts one past the last served requester so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req_valid[j] && (((int'(last_grant) + 1 + k) % NREQ) == j)) begin
          found  = 1'b1;
          winner = GW'(j);
        end
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (winner == GW'(j)) begin
        win_a = req_op_a[j*WIDTH +: WIDTH];
        win_b = req_op_b[j*WIDTH +: WIDTH];
      end
    end
  end

  // Expiry is flagged on the edge where the incremented count reaches TIMEOUT.
  assign expired = ({1'b0, count} + 17'd1) >= 17'(TIMEOUT);

  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_nxt       = grant_id;
    count_nxt       = count;
    req_ready_nxt   = '0;
    req_done_nxt    = '0;
    req_res_nxt     = req_res;
    mul_op_a_nxt    = mul_op_a;
    mul_op_b_nxt    = mul_op_b;
    mul_valid_nxt   = 1'b0;
    timeout_err_nxt = timeout_err;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt     = winner;
          mul_op_a_nxt  = win_a;
          mul_op_b_nxt  = win_b;
          mul_valid_nxt = 1'b1;
          req_ready_nxt = onehot(winner);
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        count_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        count_nxt = (count == 16'hFFFF) ? count : count + 16'd1;
        if (mul_done) begin
          req_res_nxt    = mul_res;
          req_done_nxt   = onehot(grant_id);
          last_grant_nxt = grant_id;
          state_nxt      = IDLE;
        end else if (expired) begin
          timeout_err_nxt = 1'b1;
          req_res_nxt     = '0;
          req_done_nxt    = onehot(grant_id);
          last_grant_nxt  = grant_id;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GW'(NREQ - 1);
      grant_id    <= '0;
      count       <= '0;
      req_ready   <= '0;
      req_done    <= '0;
      req_res     <= '0;
      mul_op_a    <= '0;
      mul_op_b    <= '0;
      mul_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant_id    <= grant_nxt;
      count       <= count_nxt;
      req_ready   <= req_ready_nxt;
      req_done    <= req_done_nxt;
      req_res     <= req_res_nxt;
      mul_op_a    <= mul_op_a_nxt;
      mul_op_b    <= mul_op_b_nxt;
      mul_valid   <= mul_valid_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// tb/tb_fe_mul_arbiter.sv - table-driven check of fe_mul_arbiter
module tb_fe_mul_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_op_a, req_op_b;
  logic [NREQ-1:0] req_ready, req_done;
  logic [W-1:0]    req_res, mul_op_a, mul_op_b, mul_res;
  logic            mul_valid, mul_done, busy, timeout_err;
  logic [1:0]      grant_id;

  int tests = 0;
  int errors = 0;

  fe_mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_ready(req_ready), .req_done(req_done), .req_res(req_res), .mul_op_a(mul_op_a),
    .mul_op_b(mul_op_b), .mul_valid(mul_valid), .mul_res(mul_res), .mul_done(mul_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    bit          hold;
    int          delay;   // WAIT cycle in which mul_done is driven; 0 = never
    logic [31:0] res;
    int          grant;
    logic [31:0] a;
    logic [31:0] b;
    logic        terr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " req_ready"}, req_ready, 0);
    chk({tag, " req_done"}, req_done, 0);
    chk({tag, " req_res"}, req_res, 0);
    chk({tag, " mul_op_a"}, mul_op_a, 0);
    chk({tag, " mul_op_b"}, mul_op_b, 0);
    chk({tag, " mul_valid"}, mul_valid, 0);
    chk({tag, " grant_id"}, grant_id, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    mul_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int steps;
    int n;
    logic [2:0] oh;
    string tag;
    tag = $sformatf("v%0d", idx);
    oh = 3'b001 << v.grant;
    req_valid = v.valid;
    steps = 0;
    do begin
      @(negedge clk);
      steps++;
    end while (!mul_valid && steps < 10);
    chk({tag, " latency"}, steps, 1);
    chk({tag, " mul_valid"}, mul_valid, 1);
    chk({tag, " grant_id"}, grant_id, v.grant);
    chk({tag, " req_ready"}, req_ready, oh);
    chk({tag, " mul_op_a"}, mul_op_a, v.a);
    chk({tag, " mul_op_b"}, mul_op_b, v.b);
    chk({tag, " busy_issue"}, busy, 1);
    if (!v.hold) req_valid = req_valid & ~oh;
    if (v.delay == 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          chk({tag, " ready_pulse"}, req_ready, 0);
          chk({tag, " valid_pulse"}, mul_valid, 0);
        end
      end while (req_done == 0 && n < 20);
      chk({tag, " timeout_cycle"}, n, 9);
    end else begin
      for (n = 1; n <= v.delay; n++) begin
        @(negedge clk);
        if (n == 1) begin
          chk({tag, " ready_pulse"}, req_ready, 0);
          chk({tag, " valid_pulse"}, mul_valid, 0);
        end
        chk({tag, " early_done"}, req_done, 0);
        chk({tag, " op_a_hold"}, mul_op_a, v.a);
        if (n == v.delay) begin
          mul_done = 1'b1;
          mul_res = v.res;
        end
      end
      @(negedge clk);
      mul_done = 1'b0;
      mul_res = '0;
    end
    chk({tag, " req_done"}, req_done, oh);
    chk({tag, " req_res"}, req_res, v.res);
    chk({tag, " timeout_err"}, timeout_err, v.terr);
    chk({tag, " busy_done"}, busy, 0);
    chk({tag, " mul_valid_done"}, mul_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t extra;
    vecs[0]  = '{3'b111, 1'b1, 1, 32'd35,  0, 32'd5,  32'd7,  1'b0};
    vecs[1]  = '{3'b111, 1'b1, 2, 32'd6,   1, 32'd2,  32'd3,  1'b0};
    vecs[2]  = '{3'b111, 1'b1, 3, 32'd143, 2, 32'd11, 32'd13, 1'b0};
    vecs[3]  = '{3'b111, 1'b1, 4, 32'd35,  0, 32'd5,  32'd7,  1'b0};
    vecs[4]  = '{3'b100, 1'b0, 2, 32'd143, 2, 32'd11, 32'd13, 1'b0};
    vecs[5]  = '{3'b101, 1'b0, 3, 32'd35,  0, 32'd5,  32'd7,  1'b0};
    vecs[6]  = '{3'b100, 1'b0, 1, 32'd143, 2, 32'd11, 32'd13, 1'b0};
    vecs[7]  = '{3'b010, 1'b0, 5, 32'd6,   1, 32'd2,  32'd3,  1'b0};
    vecs[8]  = '{3'b001, 1'b0, 0, 32'd0,   0, 32'd5,  32'd7,  1'b1};
    vecs[9]  = '{3'b010, 1'b0, 3, 32'd6,   1, 32'd2,  32'd3,  1'b1};
    vecs[10] = '{3'b100, 1'b0, 1, 32'd143, 2, 32'd11, 32'd13, 1'b1};

    req_op_a = {32'd11, 32'd2, 32'd5};
    req_op_b = {32'd13, 32'd3, 32'd7};
    mul_res = '0;
    mul_done = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // mul_done on the expiry edge beats the timeout
    do_reset();
    check_reset("reset2");
    extra = '{3'b010, 1'b0, 8, 32'd6, 1, 32'd2, 32'd3, 1'b0};
    run_vec(extra, 11);

    // stray mul_done while idle
    mul_done = 1'b1;
    mul_res = 32'd77;
    @(negedge clk);
    mul_done = 1'b0;
    mul_res = '0;
    @(negedge clk);
    chk("stray_idle busy", busy, 0);
    chk("stray_idle req_done", req_done, 0);
    chk("stray_idle req_res", req_res, 6);
    chk("stray_idle mul_valid", mul_valid, 0);

    // reset in the middle of WAIT, then a late mul_done
    req_valid = 3'b001;
    @(negedge clk);
    chk("midwait mul_valid", mul_valid, 1);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("midwait busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midwait");
    mul_done = 1'b1;
    mul_res = 32'd55;
    @(negedge clk);
    mul_done = 1'b0;
    mul_res = '0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done req_done", req_done, 0);
      chk("late_done mul_valid", mul_valid, 0);
      chk("late_done busy", busy, 0);
      chk("late_done req_res", req_res, 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
